i2s_frame_packer: RTL and testbench
===================================

# i2s_frame_packer

Sits between the I2S_Data capture instances and StreamIOvhd, replacing the single-channel `data_id`/`audio_data` latch in the top level. Detects each I2S frame boundary in the USB interface clock domain, snapshots all L/R channel words into a two-deep ping-pong buffer, and drains them as a tagged word stream (channel index plus frame id) over a valid/ready handshake. Frame overruns are dropped whole and counted, never torn.

## Interface
- `NUM_CH`, 4: stereo I2S data lines captured (1..4). Word count per frame `NW = 2*NUM_CH`.
- `_WIDTH`, 24: audio sample width.
- `SETTLE`, 4: clk cycles from detected frame edge to snapshot (2..15).

Ports:
- `clk`  in  1  USB interface clock (USBCLK_IN domain); only clock.
- `rst`  in  1  synchronous, active-high reset.
- `i2s_wclk`  in  1  word clock, asynchronous to `clk`.
- `ch_data`  in  NW*_WIDTH  word k at `[k*_WIDTH +: _WIDTH]`; k=2c is channel c L, k=2c+1 is channel c R.
- `chan_en`  in  NW  per-word enable, sampled at snapshot.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer accepts the word when high with `out_valid`.
- `out_data`  out  _WIDTH  sample.
- `out_chan`  out  3  word index k.
- `out_frame_id`  out  8  frame number.
- `out_first`  out  1  first emitted word of the frame.
- `overflow`  out  1  sticky flag; cleared only by `rst`.
- `drop_count`  out  8  dropped frames, saturates at 255.

## Operation
- Sync: `i2s_wclk` passes through two flops (s1, s2) plus one history flop (s3). A frame edge is s3=1 and s2=0, i.e. a falling edge.
- Frame counter: an 8-bit `fid` increments on every frame edge, including dropped frames, and wraps 255->0. The first frame after reset gets id 0.
- Snapshot: a settle counter loads `SETTLE` on each edge. On the cycle it reaches 0, `ch_data`, `chan_en` and `fid` are written into the free buffer. A new edge while the counter is running restarts it, and the earlier frame is abandoned without counting as a drop.
- Buffer: 2 entries, write pointer and read pointer each 1 bit, occupancy 0..2.
  - A snapshot with occupancy 2 is dropped. `drop_count` is incremented (saturating) and `overflow` is set.
  - A snapshot with `chan_en`=0 is not stored and does not count as a drop.
- Drain state machine:
  - IDLE: go to SCAN when occupancy > 0.
  - SCAN: find the lowest enabled k at or above the word pointer, then go to EMIT.
  - EMIT: hold the word until the handshake completes. After a handshake, continue to the next enabled k. After the last enabled k, free the entry and return to IDLE, or go straight to SCAN if another entry is pending.
  - Disabled words are skipped with no bubble. Scanning is a combinational priority search over NW bits.
- `out_first` is high only on the first emitted word of each entry.
- Simultaneous snapshot and entry release in the same cycle: occupancy is unchanged and the snapshot is stored, not dropped.
- `rst` during any state: buffer empties, the frame counter and settle counter clear, and every output returns to its reset value the next cycle.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `out_frame_id`=0, `out_first`=0, `overflow`=0, `drop_count`=0.
- Edge latency: a falling edge of `i2s_wclk` sampled by s1 at cycle T is detected at T+2. The snapshot occurs at T+2+`SETTLE`.
- Output latency: with the buffer empty, `out_valid` rises 2 cycles after the snapshot cycle (IDLE->SCAN, then EMIT registered).
- Throughput: one word per cycle while `out_ready`=1 within an entry. There is one bubble cycle between entries.
- Handshake: once `out_valid`=1, it and `out_data`, `out_chan`, `out_frame_id`, `out_first` stay stable until `out_valid && out_ready`. `out_valid` never depends combinationally on `out_ready`.

## Test plan
- Basic frame:
  - Stimulus: `NUM_CH`=4, `chan_en`=8'hFF, `ch_data` word k = 24'h100000+k, one wclk falling edge, `out_ready`=1.
  - Required: 8 words, `out_chan` 0..7, data 24'h100000..24'h100007, `out_frame_id`=0, `out_first` only on k=0, `out_valid` 2 cycles after the snapshot.
- Mask skip:
  - Stimulus: `chan_en`=8'b1010_0100.
  - Required: only k=2, 5, 7 emitted, back-to-back with no gaps. Then `chan_en`=0 for one frame: no output, and the next frame's id is +2.
- Backpressure:
  - Stimulus: `out_ready` toggled 1,0,0,1 repeatedly.
  - Required: every output held stable while stalled, no word lost or repeated.
- Overflow:
  - Stimulus: `out_ready`=0, four frames.
  - Required: frames 0 and 1 buffered; `drop_count`=2 and `overflow`=1 after frames 2 and 3. Then `out_ready`=1: 16 words emitted with ids 0 and 1. `drop_count` saturates at 255 after 300 dropped frames.
- Id wrap and concurrency:
  - Stimulus: 257 frames with the snapshot landing on the same cycle as the last handshake of the prior entry.
  - Required: no drop; ids run ...,254,255,0.
- Reset mid-drain:
  - Stimulus: assert `rst` for 1 cycle during word k=3.
  - Required: all outputs at reset values the next cycle; the next frame emits with id 0 from k=0.

Source files
------------

// File: rtl/i2s_frame_packer_if.sv
// Output word stream of the I2S frame packer: one tagged sample per
// valid/ready handshake, with channel index, frame id and first-word marker.
interface i2s_frame_packer_if #(
   parameter int _WIDTH = 24
);
   logic              out_valid;
   logic              out_ready;
   logic [_WIDTH-1:0] out_data;
   logic [2:0]        out_chan;
   logic [7:0]        out_frame_id;
   logic              out_first;

   modport master (
      output out_valid, out_data, out_chan, out_frame_id, out_first,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data, out_chan, out_frame_id, out_first,
      output out_ready
   );
endinterface

// File: rtl/i2s_frame_packer.sv
// I2S frame packer: detects word-clock frame edges in the clk domain,
// snapshots every L/R word of the frame into a two-entry ping-pong buffer
// and drains the enabled words as a tagged stream. Frames arriving with
// both entries full are dropped whole and counted.
module i2s_frame_packer #(
   parameter int NUM_CH = 4,
   parameter int _WIDTH = 24,
   parameter int SETTLE = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i2s_wclk,
   input  logic [2*NUM_CH*_WIDTH-1:0]   ch_data,
   input  logic [2*NUM_CH-1:0]          chan_en,
   i2s_frame_packer_if.master           out_if,
   output logic                         overflow,
   output logic [7:0]                   drop_count
);

   localparam int NW = 2 * NUM_CH;
   localparam int BW = NW * _WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t state, state_n;

   // word clock synchroniser and frame edge
   logic s1, s2, s3;
   logic frame_edge;

   // settle timer and frame numbering
   logic [3:0] settle_cnt;
   logic [7:0] fid;
   logic [7:0] cur_fid;
   logic       snap;
   logic       snap_live;
   logic       store;
   logic       drop;

   // ping-pong buffer
   logic [BW-1:0] buf_data [2];
   logic [NW-1:0] buf_en   [2];
   logic [7:0]    buf_fid  [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    occ;

   // drain side
   logic [3:0]    wptr;
   logic [NW-1:0] rd_en;
   logic [BW-1:0] rd_word;
   logic          hit;
   logic [3:0]    hit_k;
   logic          load;
   logic          load_first;
   logic          release_e;
   logic          pending;
   logic          hs;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign frame_edge = s3 & ~s2;
   assign snap       = (settle_cnt == 4'd1) && !frame_edge;
   assign snap_live  = snap && (chan_en != '0);
   // A release in the same cycle frees the entry the snapshot lands in.
   assign store      = snap_live && ((occ != 2'd2) || release_e);
   assign drop       = snap_live && (occ == 2'd2) && !release_e;
   // Another entry will be waiting once the current one is released.
   assign pending    = (occ == 2'd2) || snap_live;
   assign hs         = out_if.out_valid && out_if.out_ready;
   assign rd_en      = buf_en[rd_ptr];
   assign rd_word    = buf_data[rd_ptr];

   // Two-flop synchroniser plus history flop on the word clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= i2s_wclk;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Settle timer restarts on every edge; each edge claims the next frame id.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= 4'd0;
         fid        <= 8'd0;
         cur_fid    <= 8'd0;
      end else if (frame_edge) begin
         settle_cnt <= 4'(SETTLE);
         cur_fid    <= fid;
         fid        <= fid + 8'd1;
      end else if (settle_cnt != 4'd0) begin
         settle_cnt <= settle_cnt - 4'd1;
      end
   end

   // Snapshot storage; contents are only meaningful while counted in occ.
   always_ff @(posedge clk) begin
      if (store) begin
         buf_data[wr_ptr] <= ch_data;
         buf_en[wr_ptr]   <= chan_en;
         buf_fid[wr_ptr]  <= cur_fid;
      end
   end

   // Buffer pointers, occupancy and overrun accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         occ        <= 2'd0;
         overflow   <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         if (store) begin
            wr_ptr <= ~wr_ptr;
         end
         if (release_e) begin
            rd_ptr <= ~rd_ptr;
         end
         occ <= occ + {1'b0, store} - {1'b0, release_e};
         if (drop) begin
            overflow   <= 1'b1;
            drop_count <= sat_inc8(drop_count);
         end
      end
   end

   // Lowest enabled word at or above the word pointer in the read entry.
   always_comb begin
      hit   = 1'b0;
      hit_k = 4'd0;
      for (int k = NW - 1; k >= 0; k--) begin
         if (rd_en[k] && (k >= int'(wptr))) begin
            hit   = 1'b1;
            hit_k = 4'(k);
         end
      end
   end

   // Drain state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Drain next-state: load the next word on a handshake, release at the end.
   always_comb begin
      state_n    = state;
      load       = 1'b0;
      load_first = 1'b0;
      release_e  = 1'b0;
      case (state)
         IDLE: begin
            if (occ != 2'd0) begin
               state_n = SCAN;
            end
         end
         SCAN: begin
            if (hit) begin
               load       = 1'b1;
               load_first = 1'b1;
               state_n    = EMIT;
            end else begin
               release_e = 1'b1;
               state_n   = pending ? SCAN : IDLE;
            end
         end
         EMIT: begin
            if (hs) begin
               if (hit) begin
                  load = 1'b1;
               end else begin
                  release_e = 1'b1;
                  state_n   = pending ? SCAN : IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Registered output word and word pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_if.out_valid    <= 1'b0;
         out_if.out_data     <= '0;
         out_if.out_chan     <= 3'd0;
         out_if.out_frame_id <= 8'd0;
         out_if.out_first    <= 1'b0;
         wptr                <= 4'd0;
      end else begin
         if (load) begin
            out_if.out_valid    <= 1'b1;
            out_if.out_data     <= rd_word[hit_k * _WIDTH +: _WIDTH];
            out_if.out_chan     <= hit_k[2:0];
            out_if.out_frame_id <= buf_fid[rd_ptr];
            out_if.out_first    <= load_first;
         end else if (hs) begin
            out_if.out_valid <= 1'b0;
         end
         if (release_e) begin
            wptr <= 4'd0;
         end else if (load) begin
            wptr <= hit_k + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_i2s_frame_packer.sv
// Bench for i2s_frame_packer: random frames against a transaction-level
// model of frame ids, buffer occupancy, drops and the emitted word list.
module tb_i2s_frame_packer;

   localparam int NUM_CH = 4;
   localparam int W      = 24;
   localparam int SETTLE = 4;
   localparam int NW     = 2 * NUM_CH;

   typedef struct {
      logic [W-1:0] d;
      logic [2:0]   ch;
      logic [7:0]   id;
      logic         first;
      logic         last;
   } word_t;

   typedef struct {
      int              pre;
      logic [NW*W-1:0] d;
      logic [NW-1:0]   en;
   } snap_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            i2s_wclk = 1'b0;
   logic [NW*W-1:0] ch_data = '0;
   logic [NW-1:0]   chan_en = '0;
   logic            overflow;
   logic [7:0]      drop_count;

   i2s_frame_packer_if #(._WIDTH(W)) bus();

   i2s_frame_packer #(
      .NUM_CH(NUM_CH),
      ._WIDTH(W),
      .SETTLE(SETTLE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i2s_wclk(i2s_wclk),
      .ch_data(ch_data),
      .chan_en(chan_en),
      .out_if(bus.master),
      .overflow(overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   word_t expq[$];
   word_t logq[$];
   snap_t snapq[$];

   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         outstanding = 0;
   logic [7:0] m_fid = 8'd0;
   logic [7:0] m_drop = 8'd0;
   logic       m_ovf = 1'b0;
   int         expect_rise = -10;
   logic       prev_hs_nl = 1'b0;
   logic       prev_hs_l = 1'b0;
   logic       bp_done = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model and compare: runs at negedge, applies what the next posedge does.
   always @(negedge clk) begin
      word_t w;
      snap_t s;
      logic  comp;
      int    fk;
      int    lk;
      if (rst) begin
         expq.delete();
         snapq.delete();
         outstanding = 0;
         m_fid       = 8'd0;
         m_drop      = 8'd0;
         m_ovf       = 1'b0;
         expect_rise = -10;
         prev_hs_nl  = 1'b0;
         prev_hs_l   = 1'b0;
      end else begin
         chk("drop_count", drop_count, m_drop);
         chk("overflow", overflow, m_ovf);
         if (cyc == expect_rise)     chk("valid_latency", bus.out_valid, 1);
         if (cyc == expect_rise - 1) chk("valid_early", bus.out_valid, 0);
         if (prev_hs_nl)             chk("gap_in_entry", bus.out_valid, 1);
         if (prev_hs_l)              chk("bubble_between_entries", bus.out_valid, 0);
         prev_hs_nl = 1'b0;
         prev_hs_l  = 1'b0;
         comp       = 1'b0;
         if (bus.out_valid) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_word: got chan=%0d id=%0d data=%0h, expected no word",
                        bus.out_chan, bus.out_frame_id, bus.out_data);
            end else begin
               w = expq[0];
               chk("word{data,chan,id,first}",
                   {bus.out_data, bus.out_chan, bus.out_frame_id, bus.out_first},
                   {w.d, w.ch, w.id, w.first});
               if (bus.out_ready) begin
                  void'(expq.pop_front());
                  logq.push_back(w);
                  if (w.last) begin
                     outstanding--;
                     comp      = 1'b1;
                     prev_hs_l = 1'b1;
                  end else begin
                     prev_hs_nl = 1'b1;
                  end
               end
            end
         end
         if (snapq.size() > 0 && snapq[0].pre == cyc) begin
            s = snapq.pop_front();
            if (s.en != '0) begin
               if (outstanding < 2) begin
                  if (outstanding == 0 && !comp && !bus.out_valid) expect_rise = cyc + 3;
                  fk = -1;
                  lk = -1;
                  for (int k = 0; k < NW; k++) begin
                     if (s.en[k]) begin
                        if (fk < 0) fk = k;
                        lk = k;
                     end
                  end
                  for (int k = 0; k < NW; k++) begin
                     if (s.en[k]) begin
                        w.d     = s.d[k*W +: W];
                        w.ch    = 3'(k);
                        w.id    = m_fid;
                        w.first = (k == fk);
                        w.last  = (k == lk);
                        expq.push_back(w);
                     end
                  end
                  outstanding++;
               end else begin
                  if (m_drop != 8'hFF) m_drop++;
                  m_ovf = 1'b1;
               end
            end
            m_fid++;
         end
      end
   end

   task automatic frame(input logic [NW*W-1:0] d, input logic [NW-1:0] en,
                        input int hi, input int lo);
      snap_t s;
      ch_data  = d;
      chan_en  = en;
      i2s_wclk = 1'b1;
      repeat (hi) @(posedge clk);
      #1;
      i2s_wclk = 1'b0;
      s.pre = cyc + 2 + SETTLE;
      s.d   = d;
      s.en  = en;
      snapq.push_back(s);
      repeat (lo) @(posedge clk);
      #1;
   endtask

   function automatic logic [NW*W-1:0] rand_data();
      logic [NW*W-1:0] d;
      for (int k = 0; k < NW; k++) d[k*W +: W] = W'($urandom);
      return d;
   endfunction

   task automatic wait_drain(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #1;
         if (expq.size() == 0 && snapq.size() == 0 && !bus.out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL %s: drain timeout, %0d words still expected", nm, expq.size());
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_valid"}, bus.out_valid, 0);
      chk({nm, "_data"}, bus.out_data, 0);
      chk({nm, "_chan"}, bus.out_chan, 0);
      chk({nm, "_frame_id"}, bus.out_frame_id, 0);
      chk({nm, "_first"}, bus.out_first, 0);
      chk({nm, "_overflow"}, overflow, 0);
      chk({nm, "_drop_count"}, drop_count, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [NW*W-1:0] d;
      bit found;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_reset_outputs("reset");

      // basic frame
      bus.out_ready = 1'b1;
      for (int k = 0; k < NW; k++) d[k*W +: W] = 24'h100000 + W'(k);
      logq.delete();
      frame(d, 8'hFF, 3, 7);
      wait_drain("basic");
      chk("basic_count", logq.size(), 8);
      chk("basic_w0_data", logq[0].d, 24'h100000);
      chk("basic_w7_data", logq[7].d, 24'h100007);
      chk("basic_w7_chan", logq[7].ch, 7);
      chk("basic_id", logq[0].id, 0);

      // mask skip, then an all-disabled frame
      logq.delete();
      frame(rand_data(), 8'b1010_0100, 3, 7);
      wait_drain("mask");
      frame(rand_data(), 8'h00, 3, 7);
      frame(rand_data(), 8'hFF, 3, 7);
      wait_drain("mask_next");
      chk("mask_count", logq.size(), 11);
      chk("mask_chans", {logq[0].ch, logq[1].ch, logq[2].ch}, {3'd2, 3'd5, 3'd7});
      chk("mask_id", logq[0].id, 1);
      chk("after_empty_id", logq[3].id, 3);

      // backpressure with random masks and frame spacing
      bp_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++)
               frame(rand_data(), 8'($urandom_range(1, 255)), 3, 7 + $urandom_range(0, 8));
            bp_done = 1'b1;
         end
         begin
            int ph = 0;
            while (!bp_done) begin
               bus.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
               ph++;
               @(posedge clk);
               #1;
            end
         end
      join
      bus.out_ready = 1'b1;
      wait_drain("backpressure");

      // reset mid-drain
      do_reset();
      frame(rand_data(), 8'hFF, 3, 0);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid && bus.out_chan == 3'd3) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL reset_mid_wait: word k=3 not seen, expected within 100 cycles");
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk_reset_outputs("reset_mid");
      logq.delete();
      frame(rand_data(), 8'hFF, 3, 7);
      wait_drain("after_reset");
      chk("after_reset_id", logq[0].id, 0);
      chk("after_reset_chan", logq[0].ch, 0);

      // overflow: two frames held, two dropped
      do_reset();
      bus.out_ready = 1'b0;
      logq.delete();
      for (int i = 0; i < 4; i++) frame(rand_data(), 8'hFF, 3, 7);
      chk("ovf_drop_count", drop_count, 2);
      chk("ovf_flag", overflow, 1);
      bus.out_ready = 1'b1;
      wait_drain("overflow_drain");
      chk("ovf_words", logq.size(), 16);
      chk("ovf_ids", {logq[0].id, logq[8].id, logq[15].id}, {8'd0, 8'd1, 8'd1});

      // drop counter saturation
      bus.out_ready = 1'b0;
      for (int i = 0; i < 300; i++) frame(rand_data(), 8'hFF, 1, 7);
      chk("drop_saturate", drop_count, 255);

      // id wrap with snapshots meeting entry releases
      do_reset();
      bus.out_ready = 1'b1;
      logq.delete();
      for (int i = 0; i < 257; i++) frame(rand_data(), 8'hFF, 3, 7);
      wait_drain("wrap");
      chk("wrap_words", logq.size(), 257 * 8);
      chk("wrap_ids", {logq[254*8].id, logq[255*8].id, logq[256*8].id}, {8'd254, 8'd255, 8'd0});
      chk("wrap_no_drop", drop_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
